// File: rtl/counter_sequencer.sv
// Sweep controller for a WIDTH-bit mod-N counter: start, up/down sweep, pause, stop, terminal count.
// Build option COUNTER_SEQ_AUTO_RELOAD_EN: terminal count reloads the sweep instead of going to DONE.
//
// state | meaning
// IDLE  | waiting for start; count holds its last value
// RUN   | counting one step per cycle unless paused or stopped
// PAUSE | sweep suspended, count held
// DONE  | terminal count reached; done pulses for this one cycle
module counter_sequencer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] mod_q, mod_n;
  logic             dir_q, dir_n;
  logic             done_q;
  logic [WIDTH-1:0] term, init, start_init;
  logic             advance;

  // A modulus of zero wraps to all-ones here, giving the full 2^WIDTH range.
  assign term       = dir_q ? '0 : mod_q - ONE;
  assign init       = dir_q ? mod_q - ONE : '0;
  assign start_init = dir ? mod_val - ONE : '0;

  assign advance = (state_q == RUN) && !stop && !pause;
  assign tc      = advance && (count_q == term);

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    mod_n   = mod_q;
    dir_n   = dir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mod_n   = mod_val;
          dir_n   = dir;
          count_n = start_init;
          state_n = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (pause) begin
          state_n = PAUSE;
        end else if (tc) begin
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
          count_n = init;
`else
          state_n = DONE;
`endif
        end else begin
          count_n = dir_q ? count_q - ONE : count_q + ONE;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_n = IDLE;
        end else if (!pause) begin
          state_n = RUN;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q <= IDLE;
      count_q <= '0;
      mod_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      mod_q   <= mod_n;
      dir_q   <= dir_n;
      done_q  <= (state_n == DONE);
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign done  = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: directed sweeps then random control traffic,
// checked every cycle against a behavioural model of the sweep rules.
module tb_counter_sequencer;

  localparam int W    = 3;
  localparam int FULL = 1 << W;

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic [W-1:0] mod_val = '0;
  logic         pause = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] count;
  logic [1:0]   state;
  logic         busy, tc, done;

  counter_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .clear(clear), .start(start), .dir(dir), .mod_val(mod_val),
    .pause(pause), .stop(stop), .count(count), .state(state), .busy(busy),
    .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    int   cnt;
    int   st;
    bit   busy;
    bit   done;
    bit   tc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Behavioural model: phase 0 idle, 1 running, 2 paused, 3 finished (matches output encoding).
  bit   m_valid = 0;
  int   m_phase = 0;
  int   m_cnt = 0;
  int   m_len = FULL;
  bit   m_down = 0;

  task automatic drive(input bit c, input bit s, input bit d, input int m,
                       input bit p, input bit sp);
    exp_t e;
    int   last;
    bit   at_end;
    @(posedge clk);
    #2;
    cyc++;
    clear = c; start = s; dir = d; mod_val = W'(m); pause = p; stop = sp;
    last   = m_down ? 0 : m_len - 1;
    at_end = (m_phase == 1) && !sp && !p && (m_cnt == last);
    if (m_valid) begin
      e.cyc  = cyc;
      e.cnt  = m_cnt;
      e.st   = m_phase;
      e.busy = (m_phase == 1) || (m_phase == 2);
      e.done = (m_phase == 3);
      e.tc   = at_end;
      exp_q.push_back(e);
    end
    if (!c) begin
      m_valid = 1; m_phase = 0; m_cnt = 0; m_len = FULL; m_down = 0;
    end else begin
      case (m_phase)
        0: if (s) begin
             m_len   = (m == 0) ? FULL : m;
             m_down  = d;
             m_cnt   = d ? m_len - 1 : 0;
             m_phase = 1;
           end
        1: if (sp) m_phase = 0;
           else if (p) m_phase = 2;
           else if (at_end) begin
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
             m_cnt = m_down ? m_len - 1 : 0;
`else
             m_phase = 3;
`endif
           end else m_cnt = m_down ? m_cnt - 1 : m_cnt + 1;
        2: if (sp) m_phase = 0;
           else if (!p) m_phase = 1;
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic chk(input string name, input int c, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, c, got, want);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count", e.cyc, int'(count), e.cnt);
        chk("state", e.cyc, int'(state), e.st);
        chk("busy",  e.cyc, int'(busy),  int'(e.busy));
        chk("done",  e.cyc, int'(done),  int'(e.done));
        chk("tc",    e.cyc, int'(tc),    int'(e.tc));
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Up sweep mod 6 to completion
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 6, 0, 0);
    idle_cycles(10);
    // Full-range down sweep
    drive(1, 1, 1, 0, 0, 0);
    idle_cycles(11);
    // Pause at count 2 for three cycles
    drive(1, 1, 0, 6, 0, 0);
    idle_cycles(2);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 6, 1, 0);
    idle_cycles(6);
    // Stop and pause together at count 4
    drive(1, 1, 0, 6, 0, 0);
    idle_cycles(4);
    drive(1, 0, 0, 6, 1, 1);
    idle_cycles(2);
    // Reset mid-run with start held high
    drive(1, 1, 0, 6, 0, 0);
    idle_cycles(3);
    drive(0, 1, 1, 5, 0, 0);
    drive(0, 1, 1, 5, 0, 0);
    idle_cycles(2);
    // Modulus 1 and a mid-sweep change of mod_val/dir that must be ignored
    drive(1, 1, 0, 1, 0, 0);
    idle_cycles(3);
    drive(1, 1, 0, 3, 0, 0);
    drive(1, 1, 1, 7, 0, 0);
    idle_cycles(8);
    // Random control traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 1) == 1),
            1'($urandom),
            int'($urandom_range(0, FULL - 1)),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 39) == 0));
    end
    idle_cycles(2);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", cyc, exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
